// File: rtl/vector_multiply_add_pipe_if.sv
// Operand/result bundle for vector_multiply_add_pipe: input side (in_valid/in_ready plus operands)
// and output side (out_valid/out_ready plus vd).
interface vector_multiply_add_pipe_if #(
    parameter int VLEN = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [1:0]        sew;
    logic              vm;
    logic [VLEN/8-1:0] v0;
    logic [VLEN-1:0]   vs2;
    logic [VLEN-1:0]   vs1;
    logic [VLEN-1:0]   vdd;
    logic              out_valid;
    logic              out_ready;
    logic [VLEN-1:0]   vd;

    modport master (
        output in_valid, op, sew, vm, v0, vs2, vs1, vdd, out_ready,
        input  in_ready, out_valid, vd
    );

    modport slave (
        input  in_valid, op, sew, vm, v0, vs2, vs1, vdd, out_ready,
        output in_ready, out_valid, vd
    );
endinterface

// File: rtl/vector_multiply_add_pipe.sv
// Pipelined SEW-selectable vector multiply-add (vmacc/vnmsac/vmadd/vnmsub), STAGES cycles deep.
// Define VMADD_PIPE_MASK_EN to leave v0-masked elements (vm=0) equal to the old destination vdd.
module vector_multiply_add_pipe #(
    parameter int VLEN   = 128,
    parameter int STAGES = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    vector_multiply_add_pipe_if.slave bus
);
    // Handshake: a bundle moves on clock edges where valid && ready.  The stall is global:
    // when out_valid && !out_ready every stage holds, and in_ready = !out_valid || out_ready.
    logic stall;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    logic [STAGES:1] valid_q;
    logic [1:0]      s1_op;
    logic [1:0]      s1_sew;
    logic [VLEN-1:0] s1_vs1;
    logic [VLEN-1:0] s1_vs2;
    logic [VLEN-1:0] s1_vdd;
`ifdef VMADD_PIPE_MASK_EN
    logic              s1_vm;
    logic [VLEN/8-1:0] s1_v0;
`endif
    logic [VLEN-1:0] res_q [2:STAGES];
    logic [VLEN-1:0] result;

    function automatic logic [63:0] mac_elem(input logic [1:0]  op,
                                             input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic [63:0] c);
        logic [63:0] r;
        case (op)
            2'b00:   r = a * b + c;
            2'b01:   r = c - a * b;
            2'b10:   r = a * c + b;
            default: r = b - a * c;
        endcase
        return r;
    endfunction

    // One lane array per element width; only the low W bits of each operand reach the math,
    // so wrap-around modulo 2^SEW falls out of the truncation.
    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int W = 8 << g;
        logic [VLEN-1:0] res;

        always_comb begin
            logic [63:0] ea;
            logic [63:0] eb;
            logic [63:0] ec;
            logic [63:0] er;
            ea  = '0;
            eb  = '0;
            ec  = '0;
            er  = '0;
            res = '0;
            for (int i = 0; i < VLEN / W; i++) begin
                ea         = '0;
                eb         = '0;
                ec         = '0;
                ea[W-1:0]  = s1_vs1[i*W +: W];
                eb[W-1:0]  = s1_vs2[i*W +: W];
                ec[W-1:0]  = s1_vdd[i*W +: W];
                er         = mac_elem(s1_op, ea, eb, ec);
                res[i*W +: W] = er[W-1:0];
`ifdef VMADD_PIPE_MASK_EN
                if (!s1_vm && !s1_v0[i]) begin
                    res[i*W +: W] = s1_vdd[i*W +: W];
                end
`endif
            end
        end
    end

    always_comb begin
        result = '0;
        case (s1_sew)
            2'b00:   result = g_sew[0].res;
            2'b01:   result = g_sew[1].res;
            2'b10:   result = g_sew[2].res;
            default: result = g_sew[3].res;
        endcase
    end

    // Data registers only load behind a valid bit so vd keeps its last value when the pipe drains.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            s1_op   <= '0;
            s1_sew  <= '0;
            s1_vs1  <= '0;
            s1_vs2  <= '0;
            s1_vdd  <= '0;
`ifdef VMADD_PIPE_MASK_EN
            s1_vm   <= '0;
            s1_v0   <= '0;
`endif
            for (int k = 2; k <= STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else if (!stall) begin
            valid_q <= {valid_q[STAGES-1:1], bus.in_valid};
            if (bus.in_valid) begin
                s1_op  <= bus.op;
                s1_sew <= bus.sew;
                s1_vs1 <= bus.vs1;
                s1_vs2 <= bus.vs2;
                s1_vdd <= bus.vdd;
`ifdef VMADD_PIPE_MASK_EN
                s1_vm  <= bus.vm;
                s1_v0  <= bus.v0;
`endif
            end
            if (valid_q[1]) begin
                res_q[2] <= result;
            end
            for (int k = 3; k <= STAGES; k++) begin
                if (valid_q[k-1]) begin
                    res_q[k] <= res_q[k-1];
                end
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES];
    assign bus.vd        = res_q[STAGES];
endmodule

// File: tb/tb_vector_multiply_add_pipe.sv
// Directed bench for vector_multiply_add_pipe (VLEN=128, STAGES=3); mask expectations follow
// whether VMADD_PIPE_MASK_EN is defined for the build.
module tb_vector_multiply_add_pipe;
  localparam int VLEN   = 128;
  localparam int STAGES = 3;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  logic [VLEN-1:0] exp_q[$];

  always #5 clock = ~clock;

  vector_multiply_add_pipe_if #(.VLEN(VLEN)) bus ();

  vector_multiply_add_pipe #(.VLEN(VLEN), .STAGES(STAGES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic send_bundle(input logic [1:0] op, input logic [1:0] sew,
                             input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                             input logic [VLEN-1:0] c, input logic vm,
                             input logic [VLEN/8-1:0] v0);
    int guard;
    @(negedge clock);
    bus.op = op; bus.sew = sew; bus.vs1 = a; bus.vs2 = b; bus.vdd = c;
    bus.vm = vm; bus.v0 = v0; bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard == 50) begin
      checks++; failures++;
      $display("FAIL send_accept in_ready never rose, got=%b exp=1", bus.in_ready);
    end
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (bus.out_valid === 1'b1) return;
    end
    cycles = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = '0; bus.sew = '0;
    bus.vm = 1'b1; bus.v0 = '0; bus.vs1 = '0; bus.vs2 = '0; bus.vdd = '0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.vd !== '0) begin failures++; $display("FAIL rst_vd got=%h exp=0", bus.vd); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_vmacc_sew8();
    int cyc;
    logic [VLEN-1:0] exp;
    exp = {16{8'h10}};
    send_bundle(2'b00, 2'b00, {16{8'h03}}, {16{8'h05}}, {16{8'h01}}, 1'b1, '0);
    wait_out(cyc);
    checks++; if (cyc !== STAGES) begin failures++; $display("FAIL vmacc8_latency got=%0d exp=%0d", cyc, STAGES); end
    checks++; if (bus.vd !== exp) begin failures++; $display("FAIL vmacc8_vd got=%h exp=%h", bus.vd, exp); end
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.vd !== exp) begin failures++; $display("FAIL idle_vd_hold got=%h exp=%h", bus.vd, exp); end
  endtask

  task automatic test_wrap_sew16();
    int cyc;
    logic [VLEN-1:0] exp;
    exp = {8{16'h0001}};
    send_bundle(2'b00, 2'b01, {8{16'hFFFF}}, {8{16'h0002}}, {8{16'h0003}}, 1'b1, '0);
    wait_out(cyc);
    checks++; if (cyc !== STAGES) begin failures++; $display("FAIL wrap16_latency got=%0d exp=%0d", cyc, STAGES); end
    checks++; if (bus.vd !== exp) begin failures++; $display("FAIL wrap16_vd got=%h exp=%h", bus.vd, exp); end
  endtask

  task automatic test_wide_ops();
    int cyc;
    logic [VLEN-1:0] exp;
    exp = {4{32'h0000_0004}};
    send_bundle(2'b11, 2'b10, {4{32'd2}}, {4{32'd10}}, {4{32'd3}}, 1'b1, '0);
    wait_out(cyc);
    checks++; if (bus.vd !== exp || cyc !== STAGES) begin failures++; $display("FAIL vnmsub32_vd got=%h exp=%h cyc=%0d", bus.vd, exp, cyc); end
    exp = {2{64'hFFFF_FFFF_FFFF_FFFF}};
    send_bundle(2'b01, 2'b11, {2{64'd1}}, {2{64'd1}}, '0, 1'b1, '0);
    wait_out(cyc);
    checks++; if (bus.vd !== exp || cyc !== STAGES) begin failures++; $display("FAIL vnmsac64_vd got=%h exp=%h cyc=%0d", bus.vd, exp, cyc); end
  endtask

  task automatic test_vmadd_sew8();
    int cyc;
    logic [VLEN-1:0] exp;
    exp = {16{8'h0F}};
    send_bundle(2'b10, 2'b00, {16{8'h02}}, {16{8'h01}}, {16{8'h07}}, 1'b1, '0);
    wait_out(cyc);
    checks++; if (bus.vd !== exp || cyc !== STAGES) begin failures++; $display("FAIL vmadd8_vd got=%h exp=%h cyc=%0d", bus.vd, exp, cyc); end
  endtask

  task automatic test_mask();
    int cyc;
    logic [VLEN-1:0] exp;
`ifdef VMADD_PIPE_MASK_EN
    exp = {8{16'h0110}};
`else
    exp = {16{8'h10}};
`endif
    send_bundle(2'b00, 2'b00, {16{8'h03}}, {16{8'h05}}, {16{8'h01}}, 1'b0, 16'h5555);
    wait_out(cyc);
    checks++; if (bus.vd !== exp || cyc !== STAGES) begin failures++; $display("FAIL mask8_vd got=%h exp=%h cyc=%0d", bus.vd, exp, cyc); end
    // sew=16 has eight elements: v0[15:8] must have no effect
`ifdef VMADD_PIPE_MASK_EN
    exp = {{4{16'h0007}}, {4{16'h0001}}};
`else
    exp = {8{16'h0007}};
`endif
    send_bundle(2'b00, 2'b01, {8{16'd2}}, {8{16'd3}}, {8{16'd1}}, 1'b0, 16'h0FF0);
    wait_out(cyc);
    checks++; if (bus.vd !== exp || cyc !== STAGES) begin failures++; $display("FAIL mask16_vd got=%h exp=%h cyc=%0d", bus.vd, exp, cyc); end
    exp = {8{16'h0007}};
    send_bundle(2'b00, 2'b01, {8{16'd2}}, {8{16'd3}}, {8{16'd1}}, 1'b1, 16'h0000);
    wait_out(cyc);
    checks++; if (bus.vd !== exp || cyc !== STAGES) begin failures++; $display("FAIL vm1_vd got=%h exp=%h cyc=%0d", bus.vd, exp, cyc); end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] held;
    logic [VLEN-1:0] exp;
    bit have_held;
    int got;
    have_held = 0;
    got = 0;
    exp_q.push_back({16{8'h0A}});
    exp_q.push_back({8{16'h004F}});
    exp_q.push_back({4{32'h0000_001F}});
    exp_q.push_back({2{64'hFFFF_FFFF_FFFF_FFFF}});
    @(negedge clock);
    bus.out_ready = 1'b0;
    fork
      begin
        send_bundle(2'b00, 2'b00, {16{8'd2}}, {16{8'd3}}, {16{8'd4}}, 1'b1, '0);
        send_bundle(2'b01, 2'b01, {8{16'd3}}, {8{16'd7}}, {8{16'd100}}, 1'b1, '0);
        send_bundle(2'b10, 2'b10, {4{32'd5}}, {4{32'd1}}, {4{32'd6}}, 1'b1, '0);
        send_bundle(2'b11, 2'b11, {2{64'd1}}, '0, {2{64'd1}}, 1'b1, '0);
      end
      begin
        for (int c = 0; c < 40 && got < 4; c++) begin
          @(negedge clock);
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready got=%b exp=0", bus.in_ready); end
            if (have_held) begin
              checks++; if (bus.vd !== held) begin failures++; $display("FAIL b2b_stable got=%h exp=%h", bus.vd, held); end
            end
            held = bus.vd;
            have_held = 1;
          end
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            exp = exp_q.pop_front();
            checks++; if (bus.vd !== exp) begin failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", got, bus.vd, exp); end
            got++;
          end
          @(posedge clock);
          #1;
          if (c == 5) bus.out_ready = 1'b1;
        end
      end
    join
    checks++; if (got != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got); end
    checks++; if (have_held == 0) begin failures++; $display("FAIL b2b_stall_seen got=0 exp=1"); end
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra got=%b exp=0", bus.out_valid); end
    exp_q.delete();
  endtask

  task automatic test_reset_in_flight();
    int seen;
    bus.out_ready = 1'b1;
    send_bundle(2'b00, 2'b00, {16{8'h03}}, {16{8'h05}}, {16{8'h01}}, 1'b1, '0);
    send_bundle(2'b00, 2'b01, {8{16'd2}}, {8{16'd3}}, {8{16'd1}}, 1'b1, '0);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.vd !== '0) begin failures++; $display("FAIL rif_vd got=%h exp=0", bus.vd); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rif_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rif_ghost got=%0d exp=0", seen); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rif_in_ready_after got=%b exp=1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_vmacc_sew8();
    test_wrap_sew16();
    test_wide_ops();
    test_vmadd_sew8();
    test_mask();
    test_back_to_back();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
